// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared display package: scan FSM encoding, hex segment patterns and parameter limits.
// Pure definitions; no latency or backpressure of its own.
package seg7_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } scan_state_e;

  localparam int MIN_DIGITS = 1;
  localparam int MAX_DIGITS = 8;
  localparam int MIN_BLANK  = 1;

  localparam logic [6:0] SEG_OFF = 7'b0000000;

  // Index is the nibble value; bit 0 = top segment, bit 6 = middle.
  localparam logic [6:0] SEG_HEX [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1100111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

  function automatic bit scan_params_ok(input int nd, input int ps, input int bc);
    return (nd >= MIN_DIGITS) && (nd <= MAX_DIGITS) && (bc >= MIN_BLANK) && (ps > bc);
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_hexdec.sv
// Hex nibble to 7-segment pattern decoder, purely combinational (zero latency).
// No handshake; caller gates and registers the result.
module seg7_scan_ctrl_hexdec
  import seg7_scan_ctrl_pkg::*;
(
  input  logic [3:0] nibble_dat,
  output logic [6:0] seg_dat
);

  assign seg_dat = SEG_HEX[nibble_dat];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller; outputs registered, one-deep pending value buffer.
// load_ready drops while a value is pending; it commits at the frame boundary (or next cycle in IDLE).
module seg7_scan_ctrl
  import seg7_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    lz_blank,
  input  logic                    load_valid,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  output logic                    load_ready,
  output logic [6:0]              segments,
  output logic [NUM_DIGITS-1:0]   digit_en
);

  localparam int CNT_W = $clog2(PRESCALE);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DAT_W = 4 * NUM_DIGITS;

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  if (!scan_params_ok(NUM_DIGITS, PRESCALE, BLANK_CYCLES)) begin : g_bad_params
    $error("seg7_scan_ctrl: illegal NUM_DIGITS/PRESCALE/BLANK_CYCLES");
  end

  scan_state_e            state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [DAT_W-1:0]       disp_q, disp_d;
  logic [DAT_W-1:0]       pend_q, pend_d;
  logic                   pend_vld_q, pend_vld_d;
  logic                   load_ready_q, load_ready_d;
  logic [6:0]             segments_q, segments_d;
  logic [NUM_DIGITS-1:0]  digit_en_q, digit_en_d;

  logic                   frame_end;
  logic                   accept;
  logic                   commit;
  logic [3:0]             disp_nib [NUM_DIGITS];
  logic [3:0]             dec_nib;
  logic [6:0]             dec_seg;
  logic                   run_zero;
  logic                   lz_hide;

  assign frame_end = (state_q == ST_SHOW) && (cnt_q == CNT_LAST) && (idx_q == IDX_LAST);
  assign accept    = load_valid && load_ready_q;
  assign commit    = pend_vld_q && ((state_q == ST_IDLE) || frame_end);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    disp_d     = disp_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;

    // Commit empties pending before accept can refill it, so an accepted value
    // always waits for a later commit point.
    if (commit) begin
      disp_d     = pend_q;
      pend_vld_d = 1'b0;
    end
    if (accept) begin
      pend_d     = load_data;
      pend_vld_d = 1'b1;
    end

    if (!enable) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          idx_d   = '0;
        end
        ST_BLANK: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == BLANK_LAST) begin
            state_d = ST_SHOW;
          end
        end
        ST_SHOW: begin
          if (cnt_q == CNT_LAST) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
            idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end
      endcase
    end

    load_ready_d = !pend_vld_d;
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_nib
    assign disp_nib[g] = disp_d[4*g +: 4];
  end

  // Decode from next-cycle state so registered outputs match the state they are held with.
  assign dec_nib = disp_nib[idx_d];

  seg7_scan_ctrl_hexdec u_hexdec (
    .nibble_dat (dec_nib),
    .seg_dat    (dec_seg)
  );

  always_comb begin
    run_zero   = 1'b1;
    lz_hide    = 1'b0;
    digit_en_d = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run_zero = run_zero && (disp_nib[i] == 4'h0);
      if ((i != 0) && (idx_d == IDX_W'(i))) begin
        lz_hide = run_zero;
      end
      digit_en_d[i] = (state_d == ST_SHOW) && (idx_d == IDX_W'(i));
    end
    segments_d = ((state_d == ST_SHOW) && !(lz_blank && lz_hide)) ? dec_seg : SEG_OFF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      disp_q       <= '0;
      pend_q       <= '0;
      pend_vld_q   <= 1'b0;
      load_ready_q <= 1'b1;
      segments_q   <= SEG_OFF;
      digit_en_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      disp_q       <= disp_d;
      pend_q       <= pend_d;
      pend_vld_q   <= pend_vld_d;
      load_ready_q <= load_ready_d;
      segments_q   <= segments_d;
      digit_en_q   <= digit_en_d;
    end
  end

  assign load_ready = load_ready_q;
  assign segments   = segments_q;
  assign digit_en   = digit_en_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: directed scenarios then random traffic, checked every cycle
// against a timeline model (slot = t / PRESCALE, phase = t % PRESCALE).
module tb_seg7_scan_ctrl;

  localparam int N  = 4;
  localparam int P  = 8;
  localparam int B  = 2;
  localparam int NP = N * P;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            enable = 1'b0;
  logic            lz_blank = 1'b0;
  logic            load_valid = 1'b0;
  logic [4*N-1:0]  load_data = '0;
  logic            load_ready;
  logic [6:0]      segments;
  logic [N-1:0]    digit_en;

  int tests = 0;
  int fails = 0;

  logic [6:0] hex_tbl [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1100111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

  // Model: m_t counts cycles since the scan started (mod one frame).
  bit          m_run;
  int          m_t;
  logic [15:0] m_disp;
  logic [15:0] m_pend;
  bit          m_full;
  logic [6:0]  e_seg;
  logic [N-1:0] e_den;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(.NUM_DIGITS(N), .PRESCALE(P), .BLANK_CYCLES(B)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .lz_blank   (lz_blank),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .segments   (segments),
    .digit_en   (digit_en)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_t = 0; m_disp = '0; m_pend = '0; m_full = 0;
    e_seg = '0; e_den = '0;
  endtask

  task automatic model_step();
    bit boundary;
    int d;
    boundary = m_run && (m_t % P == P - 1) && ((m_t / P) % N == N - 1);
    if (m_full && (!m_run || boundary)) begin
      m_disp = m_pend;
      m_full = 0;
    end else if (load_valid && !m_full) begin
      m_pend = load_data;
      m_full = 1;
    end
    if (!enable) begin
      m_run = 0; m_t = 0;
    end else if (!m_run) begin
      m_run = 1; m_t = 0;
    end else begin
      m_t = (m_t + 1) % NP;
    end
    e_seg = '0;
    e_den = '0;
    if (m_run && (m_t % P) >= B) begin
      d = (m_t / P) % N;
      e_den[d] = 1'b1;
      if (!(lz_blank && d > 0 && (m_disp >> (4 * d)) == 16'h0))
        e_seg = hex_tbl[(m_disp >> (4 * d)) & 16'hF];
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      model_step();
      #1;
      chk("segments", 16'(segments), 16'(e_seg));
      chk("digit_en", 16'(digit_en), 16'(e_den));
      chk("load_ready", 16'(load_ready), 16'(!m_full));
      @(negedge clk);
    end
  endtask

  // Holds load_valid until the DUT takes the value; returns the model time of acceptance.
  task automatic offer(input logic [15:0] d, output int acc_t);
    bit r;
    int t_before;
    acc_t = -1;
    load_valid = 1'b1;
    load_data  = d;
    for (int k = 0; k < 200; k++) begin
      r = load_ready;
      t_before = m_t;
      tick(1);
      if (r) begin
        acc_t = t_before;
        break;
      end
    end
    load_valid = 1'b0;
    chk("offer_accepted", 16'(acc_t >= 0), 16'd1);
  endtask

  task automatic sync_frame_end();
    int k;
    k = 0;
    do begin
      tick(1);
      k++;
    end while (!(m_run && m_t == NP - 1) && k < 200);
    chk("sync_frame_end", 16'(m_run && m_t == NP - 1), 16'd1);
  endtask

  initial begin
    int acc;
    int k;
    logic [6:0] lit_seg [4];
    logic [6:0] lz_seg  [4];

    model_reset();
    // Reset state
    #1 rst_n = 1'b0;
    #1;
    chk("rst_segments", 16'(segments), 16'h0);
    chk("rst_digit_en", 16'(digit_en), 16'h0);
    chk("rst_load_ready", 16'(load_ready), 16'h1);
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);

    // Load 12AF in IDLE, then scan F, A, 2, 1 and wrap
    offer(16'h12AF, acc);
    tick(1);
    enable = 1'b1;
    lit_seg = '{7'b1110001, 7'b1110111, 7'b1011011, 7'b0000110};
    for (int d = 0; d < N; d++) begin
      for (int c = 0; c < B; c++) begin
        tick(1);
        chk("blank_digit_en", 16'(digit_en), 16'h0);
        chk("blank_segments", 16'(segments), 16'h0);
      end
      for (int c = 0; c < P - B; c++) begin
        tick(1);
        chk("show_digit_en", 16'(digit_en), 16'(1 << d));
        chk("show_segments", 16'(segments), 16'(lit_seg[d]));
      end
    end
    tick(B + 1);
    chk("wrap_digit_en", 16'(digit_en), 16'h1);
    chk("wrap_segments", 16'(segments), 16'(7'b1110001));

    // Leading-zero suppression on 0070
    lz_blank = 1'b1;
    offer(16'h0070, acc);
    sync_frame_end();
    lz_seg = '{7'b0111111, 7'b0000111, 7'b0000000, 7'b0000000};
    for (int d = 0; d < N; d++) begin
      tick(B);
      for (int c = 0; c < P - B; c++) begin
        tick(1);
        chk("lz_digit_en", 16'(digit_en), 16'(1 << d));
        chk("lz_segments", 16'(segments), 16'(lz_seg[d]));
      end
    end
    lz_blank = 1'b0;

    // Load during digit 1 stays pending until the frame boundary
    offer(16'h2222, acc);
    sync_frame_end();
    k = 0;
    while (m_t != P + B && k < 100) begin
      tick(1);
      k++;
    end
    offer(16'h1111, acc);
    chk("pend_load_ready", 16'(load_ready), 16'h0);
    k = 0;
    while (m_t != NP - 1 && k < 100) begin
      tick(1);
      k++;
      if (digit_en != '0) chk("old_frame_segments", 16'(segments), 16'(7'b1011011));
      chk("pend_hold_ready", 16'(load_ready), 16'h0);
    end
    tick(1);
    chk("ready_after_boundary", 16'(load_ready), 16'h1);
    k = 0;
    while (m_t != NP - 1 && k < 100) begin
      tick(1);
      k++;
      if (digit_en != '0) chk("new_frame_segments", 16'(segments), 16'(7'b0000110));
    end

    // Accept on the boundary cycle, then a held second value
    offer(16'h3333, acc);
    chk("boundary_accept_t", 16'(acc), 16'(NP - 1));
    tick(B);
    chk("no_same_cycle_commit", 16'(segments), 16'(7'b0000110));
    offer(16'h4444, acc);
    chk("held_accept_t", 16'(acc), 16'h0);
    tick(B - 1);
    chk("first_value_shown", 16'(segments), 16'(7'b1001111));
    sync_frame_end();
    tick(B + 1);
    chk("second_value_shown", 16'(segments), 16'(7'b1100110));

    // Enable dropped mid-SHOW, then restart at digit 0
    tick(2);
    enable = 1'b0;
    tick(1);
    chk("disable_digit_en", 16'(digit_en), 16'h0);
    chk("disable_segments", 16'(segments), 16'h0);
    tick(2);
    enable = 1'b1;
    tick(1);
    chk("reen_blank0", 16'(digit_en), 16'h0);
    tick(1);
    chk("reen_blank1", 16'(digit_en), 16'h0);
    tick(1);
    chk("reen_digit_en", 16'(digit_en), 16'h1);
    chk("reen_segments", 16'(segments), 16'(7'b1100110));

    // Asynchronous reset mid-SHOW with pending full
    offer(16'h5555, acc);
    chk("pend_full_before_rst", 16'(load_ready), 16'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_segments", 16'(segments), 16'h0);
    chk("arst_digit_en", 16'(digit_en), 16'h0);
    chk("arst_load_ready", 16'(load_ready), 16'h1);
    model_reset();
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);
    enable = 1'b1;
    tick(B + 1);
    chk("post_rst_digit_en", 16'(digit_en), 16'h1);
    chk("post_rst_segments", 16'(segments), 16'(7'b0111111));

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      enable     = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 63) == 0) lz_blank = ~lz_blank;
      load_valid = ($urandom_range(0, 7) == 0);
      load_data  = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      tick(1);
    end
    load_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seg7_scan_ctrl.md
SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits (legal 1..8).
REQ-002 SHALL have parameter PRESCALE, default 1000, clocks per digit slot (legal > BLANK_CYCLES).
REQ-003 SHALL have parameter BLANK_CYCLES, default 16, anti-ghost blank clocks at start of each slot (legal >= 1).
REQ-004 SHALL have ports: clk  in  1  single clock, rising edge.
REQ-005 SHALL have ports: rst_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports: enable  in  1  scan enable.
REQ-007 SHALL have ports: lz_blank  in  1  leading-zero suppression enable.
REQ-008 SHALL have ports: load_valid  in  1  new display value offered.
REQ-009 SHALL have ports: load_data  in  4*NUM_DIGITS  hex nibbles; nibble 0 (bits 3:0) is the least significant digit.
REQ-010 SHALL have ports: load_ready  out  1  controller can accept a value.
REQ-011 SHALL have ports: segments  out  7  segment drive, bit 0 = top, bit 6 = middle, active high.
REQ-012 SHALL have ports: digit_en  out  NUM_DIGITS  one-hot digit select, active high.

Function
REQ-013 SHALL transfer load_data into a pending register on a cycle with load_valid=1 and load_ready=1.
REQ-014 SHALL drive load_ready=0 whenever the pending register is full, and =1 whenever it is empty.
REQ-015 SHALL commit pending to the display register, and empty pending, at the frame boundary: the last cycle of the slot for digit NUM_DIGITS-1. load_ready SHALL return to 1 on the next cycle.
REQ-016 SHALL commit pending on the cycle after acceptance while in IDLE.
REQ-017 SHALL NOT commit a value in its own acceptance cycle. A value accepted on a frame-boundary cycle SHALL commit at the following boundary.
REQ-018 SHALL implement states IDLE, BLANK and SHOW.
REQ-019 SHALL, in IDLE: hold digit index 0, slot counter 0, segments=0, digit_en=0.
REQ-020 SHALL transition IDLE->BLANK on any cycle with enable=1.
REQ-021 SHALL stay in BLANK for exactly BLANK_CYCLES cycles, with segments=0 and digit_en=0, then go to SHOW.
REQ-022 SHALL stay in SHOW for exactly PRESCALE-BLANK_CYCLES cycles, with digit_en one-hot at the current index and segments = hex decode of the indexed display nibble.
REQ-023 SHALL go SHOW->BLANK at the end of SHOW and increment the index. The index SHALL wrap from NUM_DIGITS-1 to 0.
REQ-024 SHALL give every slot a total length of exactly PRESCALE cycles.
REQ-025 SHALL register all outputs. Output values SHALL reflect the state held during the same cycle (state and output update on the same edge).
REQ-026 SHALL go to IDLE on the next edge from any state when enable=0 is sampled. Index and counters SHALL clear; display and pending registers SHALL be kept.
REQ-027 SHALL, when lz_blank=1, force segments=0 for digit i (i>0) if nibble i and all more-significant nibbles are zero. digit_en SHALL still assert. Digit 0 SHALL always display.
REQ-028 SHALL use hex decode patterns: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1100111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001.
REQ-029 SHALL size the slot counter as clog2(PRESCALE) bits and the index as clog2(NUM_DIGITS) bits (minimum 1). Neither SHALL exceed its terminal value.

Reset
REQ-030 SHALL, on rst_n=0 and asynchronously, reset to: state IDLE; index 0; counters 0; display register 0; pending empty; segments=0; digit_en=0; load_ready=1.
REQ-031 SHALL discard any pending value on reset asserted mid-frame or mid-handshake.

Structure
REQ-032 SHALL place the state encoding, the segment-pattern constants and parameter legality limits in the shared display package.
REQ-033 SHALL reuse the team's existing seg7 hex-decoder module as its single sub-module. Its output SHALL be gated and registered in this block.

Verification (NUM_DIGITS=4, PRESCALE=8, BLANK_CYCLES=2)
REQ-034 SHALL cover: reset, load 16'h12AF in IDLE, enable -> 2 blank cycles, then 6 cycles of digit_en=0001/segments=1110001, then digits A, 2, 1 in turn, then wrap to digit 0.
REQ-035 SHALL cover: lz_blank=1, load 16'h0070 -> digits 3 and 2 segments=0000000 with digit_en asserted; digit 1 =0000111; digit 0 =0111111.
REQ-036 SHALL cover: showing 16'h2222, load 16'h1111 during digit 1 -> load_ready=0; digits 1-3 still show 1011011; next frame shows 0000110; load_ready=1 the cycle after the boundary.
REQ-037 SHALL cover: load_valid held with a second value while load_ready=0 -> accepted only on the first cycle after the commit; no value lost or duplicated.
REQ-038 SHALL cover: enable dropped mid-SHOW -> next cycle digit_en=0000 and segments=0. Re-enable -> restart at digit 0 with 2 blank cycles.
REQ-039 SHALL cover: rst_n pulsed low mid-SHOW with pending full -> outputs 0 immediately without a clock edge; after release load_ready=1 and a subsequent enable displays 0 on digit 0.
